// File: rtl/key_debounce.sv
// key_debounce
//   Per-channel two-flop synchronizer and debouncer for board push-buttons.
//   Each channel accepts a new level only after the synchronized input has
//   differed from the current clean level for DEBOUNCE_CYCLES consecutive
//   clock edges. key_clean drives the key PIO in_port directly.
//
// Parameters
//   WIDTH           number of independent key channels
//   DEBOUNCE_CYCLES consecutive differing edges needed to accept a level
//                   (1 .. 2^CNT_WIDTH-1)
//   CNT_WIDTH       width of each channel's stability counter
//   RESET_LEVEL     level loaded into synchronizers and key_clean at reset
//
// Ports
//   clk        single clock for all logic
//   reset_n    asynchronous, active-low reset
//   key_raw    asynchronous (bouncing) button inputs
//   enable     0 freezes debouncing: FSMs idle, key_clean holds
//   key_clean  registered debounced levels
//   key_rise   one-cycle strobe aligned with a 0->1 change of key_clean
//   key_fall   one-cycle strobe aligned with a 1->0 change of key_clean
//   key_busy   channel is counting a pending candidate level
module key_debounce #(
    parameter int   WIDTH           = 4,
    parameter int   DEBOUNCE_CYCLES = 1000000,
    parameter int   CNT_WIDTH       = 20,
    parameter logic RESET_LEVEL     = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] key_raw,
    input  logic             enable,
    output logic [WIDTH-1:0] key_clean,
    output logic [WIDTH-1:0] key_rise,
    output logic [WIDTH-1:0] key_fall,
    output logic [WIDTH-1:0] key_busy
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    // With a one-cycle debounce the first differing edge is already the
    // accepting edge, so the COUNT state is never entered.
    localparam bit SINGLE_CYCLE = (DEBOUNCE_CYCLES == 1);

    // Two-flop synchronizer, all channels at once
    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= {WIDTH{RESET_LEVEL}};
            s2_q <= {WIDTH{RESET_LEVEL}};
        end else begin
            s1_q <= key_raw;
            s2_q <= s1_q;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        state_e               state_q;
        state_e               state_d;
        logic [CNT_WIDTH-1:0] cnt_q;
        logic [CNT_WIDTH-1:0] cnt_d;
        logic                 clean_q;
        logic                 clean_d;
        logic                 rise_q;
        logic                 fall_q;
        logic                 differ;

        assign differ = s2_q[i] ^ clean_q;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            clean_d = clean_q;
            if (!enable) begin
                // Frozen: drop any pending candidate, keep the clean level
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        cnt_d = '0;
                        if (differ) begin
                            if (SINGLE_CYCLE) begin
                                clean_d = s2_q[i];
                            end else begin
                                state_d = ST_COUNT;
                                cnt_d   = CNT_ONE;
                            end
                        end
                    end
                    ST_COUNT: begin
                        if (!differ) begin
                            // Bounced back to the clean level: restart
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else if (cnt_q == CNT_LAST) begin
                            clean_d = s2_q[i];
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                clean_q <= RESET_LEVEL;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                clean_q <= clean_d;
                // Strobes are registered so they line up with the key_clean change
                rise_q  <= clean_d & ~clean_q;
                fall_q  <= ~clean_d & clean_q;
            end
        end

        assign key_clean[i] = clean_q;
        assign key_rise[i]  = rise_q;
        assign key_fall[i]  = fall_q;
        assign key_busy[i]  = (state_q == ST_COUNT);
    end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce
//   Scoreboard bench for key_debounce (WIDTH=4, DEBOUNCE_CYCLES=4,
//   RESET_LEVEL=1). The stimulus process drives inputs on the falling edge,
//   advances a run-length reference model and queues the outputs expected
//   after the next rising edge; a monitor pops and compares after every
//   rising edge. Directed scenarios are followed by a randomized phase.
module tb_key_debounce;

    localparam int   W  = 4;
    localparam int   DC = 4;
    localparam logic RL = 1'b1;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] key_raw;
    logic         enable;
    logic [W-1:0] key_clean;
    logic [W-1:0] key_rise;
    logic [W-1:0] key_fall;
    logic [W-1:0] key_busy;

    key_debounce #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(DC),
        .CNT_WIDTH      (3),
        .RESET_LEVEL    (RL)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .key_raw  (key_raw),
        .enable   (enable),
        .key_clean(key_clean),
        .key_rise (key_rise),
        .key_fall (key_fall),
        .key_busy (key_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] clean;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic [W-1:0] busy;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: synchronizer as a two-deep history of key_raw, and per
    // channel the number of consecutive enabled edges on which the delayed
    // input disagreed with the clean level.
    logic [W-1:0] m_s1 = {W{RL}};
    logic [W-1:0] m_s2 = {W{RL}};
    logic [W-1:0] m_clean = {W{RL}};
    int           streak[W];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step(input logic [W-1:0] raw, input logic en, input logic rst);
        exp_t         e;
        logic [W-1:0] s2_old;
        @(negedge clk);
        key_raw = raw;
        enable  = en;
        reset_n = rst;
        e = '0;
        if (!rst) begin
            m_s1    = {W{RL}};
            m_s2    = {W{RL}};
            m_clean = {W{RL}};
            for (int c = 0; c < W; c++) streak[c] = 0;
        end else begin
            s2_old = m_s2;
            m_s2   = m_s1;
            m_s1   = raw;
            for (int c = 0; c < W; c++) begin
                if (!en || s2_old[c] == m_clean[c]) begin
                    streak[c] = 0;
                end else begin
                    streak[c]++;
                    if (streak[c] == DC) begin
                        if (s2_old[c]) e.rise[c] = 1'b1;
                        else           e.fall[c] = 1'b1;
                        m_clean[c] = s2_old[c];
                        streak[c]  = 0;
                    end
                end
            end
        end
        e.clean = m_clean;
        for (int c = 0; c < W; c++) e.busy[c] = (streak[c] != 0);
        sb_q.push_back(e);
    endtask

    task automatic steps(input int n, input logic [W-1:0] raw, input logic en);
        for (int k = 0; k < n; k++) step(raw, en, 1'b1);
    endtask

    task automatic peek();
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare DUT outputs after every edge that has a queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                cyc++;
                chk($sformatf("clean[c%0d]", cyc), key_clean, e.clean);
                chk($sformatf("rise[c%0d]",  cyc), key_rise,  e.rise);
                chk($sformatf("fall[c%0d]",  cyc), key_fall,  e.fall);
                chk($sformatf("busy[c%0d]",  cyc), key_busy,  e.busy);
            end
        end
    end

    initial begin
        logic [W-1:0] r;
        logic         en;
        logic         rs;
        for (int c = 0; c < W; c++) streak[c] = 0;
        reset_n = 1'b0;
        key_raw = 4'b0000;
        enable  = 1'b1;

        // Reset held with keys low, released with keys high
        for (int k = 0; k < 3; k++) step(4'b0000, 1'b1, 1'b0);
        steps(8, 4'b1111, 1'b1);

        // Clean press on channel 0
        step(4'b1110, 1'b1, 1'b1);            // E0
        step(4'b1110, 1'b1, 1'b1);            // E0+1
        step(4'b1110, 1'b1, 1'b1);            // E0+2
        peek();
        chk("press_busy_e2", key_busy, 4'b0001);
        chk("press_clean_e2", key_clean, 4'b1111);
        steps(2, 4'b1110, 1'b1);              // E0+3, E0+4
        step(4'b1110, 1'b1, 1'b1);            // E0+5
        peek();
        chk("press_clean_e5", key_clean, 4'b1110);
        chk("press_fall_e5", key_fall, 4'b0001);
        step(4'b1110, 1'b1, 1'b1);
        peek();
        chk("press_fall_gone", key_fall, 4'b0000);
        chk("press_busy_gone", key_busy, 4'b0000);
        steps(8, 4'b1111, 1'b1);

        // Bounce rejection on channel 1: 3 low cycles rejected, 4 accepted
        steps(3, 4'b1101, 1'b1);
        steps(8, 4'b1111, 1'b1);
        peek();
        chk("bounce3_clean", key_clean, 4'b1111);
        steps(4, 4'b1101, 1'b1);
        steps(8, 4'b1111, 1'b1);

        // Bounce restart on channel 2: low 2, high 1, low held
        steps(2, 4'b1011, 1'b1);
        steps(1, 4'b1111, 1'b1);
        steps(8, 4'b1011, 1'b1);
        steps(8, 4'b1111, 1'b1);

        // Simultaneous fall on all channels
        step(4'b0000, 1'b1, 1'b1);            // E0
        steps(4, 4'b0000, 1'b1);              // E0+1 .. E0+4
        step(4'b0000, 1'b1, 1'b1);            // E0+5
        peek();
        chk("simul_clean", key_clean, 4'b0000);
        chk("simul_fall", key_fall, 4'b1111);
        steps(8, 4'b1111, 1'b1);

        // Enable dropped at count 2, then restored
        steps(4, 4'b1110, 1'b1);              // E0 .. E0+3: count reaches 2
        step(4'b1110, 1'b0, 1'b1);
        peek();
        chk("en_off_busy", key_busy, 4'b0000);
        chk("en_off_clean", key_clean, 4'b1111);
        steps(3, 4'b1110, 1'b0);
        steps(6, 4'b1110, 1'b1);
        steps(8, 4'b1111, 1'b1);

        // Reset pulsed at count 3
        steps(5, 4'b1110, 1'b1);              // E0 .. E0+4: count reaches 3
        step(4'b1110, 1'b1, 1'b0);
        #1;
        chk("rst_async_clean", key_clean, 4'b1111);
        chk("rst_async_busy", key_busy, 4'b0000);
        steps(8, 4'b1111, 1'b1);

        // Randomized phase: bouncing keys, occasional freeze and reset
        r = 4'b1111;
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < W; c++)
                if ($urandom_range(0, 5) == 0) r[c] = ~r[c];
            en = ($urandom_range(0, 39) != 0);
            rs = ($urandom_range(0, 299) != 0);
            step(r, en, rs);
        end
        steps(8, 4'b1111, 1'b1);

        @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
